// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset PC default and the IF/ID bundle.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_KILL,
    ST_HOLD
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } ifid_t;

  // Instructions are word aligned; the low two bits of a target are discarded.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master) and memory (slave).
interface if_fetch_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             imem_req_o;
  logic [WIDTH-1:0] imem_addr_o;
  logic             imem_ack_i;
  logic [WIDTH-1:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ack_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ack_i, imem_rdata_i
  );
endinterface

// File: rtl/if_fetch_stage_hold_buf.sv
// One-entry skid buffer holding a fetched instruction that arrived while IF/ID was stalled.
module if_hold_buf
  import if_fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  logic  drop_i,
  input  ifid_t data_i,
  output ifid_t data_o
);

  ifid_t buf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
    end else if (load_i) begin
      buf_q <= data_i;
    end else if (drop_i) begin
      buf_q.valid <= 1'b0;
    end
  end

  assign data_o = buf_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, imem handshake and IF/ID register.
// Optional performance counters enabled by defining IF_FETCH_PERF_EN.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned      WIDTH    = XLEN,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic [WIDTH-1:0] pc_o,
  input  logic [WIDTH-1:0] seq_pc_i,
  if_fetch_stage_if.master imem,
  output logic             ifid_valid_o,
  output logic [WIDTH-1:0] ifid_pc_o,
  output logic [WIDTH-1:0] ifid_pc4_o,
  output logic [WIDTH-1:0] ifid_instr_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch_o,
  output logic [31:0]      perf_bubble_o
`endif
);

  fetch_state_e     state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] addr_q;
  logic             req_q;
  ifid_t            ifid_q;
  ifid_t            buf_in;
  ifid_t            buf_out;
  logic [WIDTH-1:0] redir_pc;
  logic             ack;
  logic             buf_load;
  logic             buf_drop;

  assign ack      = imem.imem_ack_i;
  assign redir_pc = align_pc(redirect_pc_i);
  assign buf_load = (state_q == ST_REQ) && ack && !redirect_i && stall_i;
  assign buf_drop = (state_q == ST_HOLD) && (redirect_i || !stall_i);
  assign buf_in   = '{valid: 1'b1, pc: pc_q, pc4: seq_pc_i, instr: imem.imem_rdata_i};

  if_hold_buf u_hold_buf (
    .clk    (clk),
    .rst    (rst),
    .load_i (buf_load),
    .drop_i (buf_drop),
    .data_i (buf_in),
    .data_o (buf_out)
  );

  // addr_q tracks the address of the request in flight; in KILL it keeps the
  // abandoned address stable while pc_q already holds the redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      ifid_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect_i) begin
            pc_q   <= redir_pc;
            addr_q <= redir_pc;
          end else begin
            addr_q <= pc_q;
          end
          req_q   <= 1'b1;
          state_q <= ST_REQ;
        end
        ST_REQ: begin
          if (ack) begin
            if (redirect_i) begin
              pc_q         <= redir_pc;
              addr_q       <= redir_pc;
              ifid_q.valid <= 1'b0;
            end else if (!stall_i) begin
              ifid_q <= '{valid: 1'b1, pc: pc_q, pc4: seq_pc_i, instr: imem.imem_rdata_i};
              pc_q   <= seq_pc_i;
              addr_q <= seq_pc_i;
            end else begin
              req_q   <= 1'b0;
              state_q <= ST_HOLD;
            end
          end else if (redirect_i) begin
            pc_q         <= redir_pc;
            ifid_q.valid <= 1'b0;
            state_q      <= ST_KILL;
          end else if (!stall_i) begin
            ifid_q.valid <= 1'b0;
          end
        end
        ST_KILL: begin
          if (redirect_i) pc_q <= redir_pc;
          if (redirect_i || !stall_i) ifid_q.valid <= 1'b0;
          if (ack) begin
            addr_q  <= redirect_i ? redir_pc : pc_q;
            state_q <= ST_REQ;
          end
        end
        ST_HOLD: begin
          if (redirect_i) begin
            pc_q         <= redir_pc;
            addr_q       <= redir_pc;
            ifid_q.valid <= 1'b0;
            req_q        <= 1'b1;
            state_q      <= ST_REQ;
          end else if (!stall_i && buf_out.valid) begin
            ifid_q  <= buf_out;
            pc_q    <= buf_out.pc4;
            addr_q  <= buf_out.pc4;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pc_o             = pc_q;
  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = addr_q;
  assign ifid_valid_o     = ifid_q.valid;
  assign ifid_pc_o        = ifid_q.pc;
  assign ifid_pc4_o       = ifid_q.pc4;
  assign ifid_instr_o     = ifid_q.instr;

`ifdef IF_FETCH_PERF_EN
  logic        fetch_ev;
  logic        bubble_ev;
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_bubble_q;

  always_comb begin
    fetch_ev  = ((state_q == ST_REQ) && ack && !redirect_i && !stall_i) ||
                ((state_q == ST_HOLD) && !redirect_i && !stall_i && buf_out.valid);
    bubble_ev = !stall_i && (((state_q == ST_REQ) && (redirect_i || !ack)) ||
                             (state_q == ST_KILL) ||
                             ((state_q == ST_HOLD) && redirect_i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (fetch_ev)  perf_fetch_q  <= perf_fetch_q + 32'd1;
      if (bubble_ev) perf_bubble_q <= perf_bubble_q + 32'd1;
    end
  end

  assign perf_fetch_o  = perf_fetch_q;
  assign perf_bubble_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a variable-latency instruction memory model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] seq_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_bubble;
`endif

  int checks = 0;
  int errors = 0;
  int lat    = 0;
  int cnt    = 0;

  if_fetch_stage_if #(.WIDTH(32)) imem_bus ();

  if_fetch_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_o          (pc),
    .seq_pc_i      (seq_pc),
    .imem          (imem_bus.master),
    .ifid_valid_o  (ifid_valid),
    .ifid_pc_o     (ifid_pc),
    .ifid_pc4_o    (ifid_pc4),
    .ifid_instr_o  (ifid_instr)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetch_o  (perf_fetch),
    .perf_bubble_o (perf_bubble)
`endif
  );

  always #5 clk = ~clk;

  // Top-level sequential adder and memory: word at address a reads as 0x1300_0000 | a.
  assign seq_pc                = pc + 32'd4;
  assign imem_bus.imem_ack_i   = imem_bus.imem_req_o && (cnt == lat);
  assign imem_bus.imem_rdata_i = 32'h1300_0000 | imem_bus.imem_addr_o;

  always @(posedge clk) begin
    if (rst || !imem_bus.imem_req_o || imem_bus.imem_ack_i) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; lat = 0;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem_bus.imem_req_o), 32'h0);
    chk("rst_valid", 32'(ifid_valid), 32'h0);
    chk("rst_ifid_pc", ifid_pc, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);

    // zero-wait memory: one instruction per cycle
    rst = 1'b0;
    step();
    chk("idle_req", 32'(imem_bus.imem_req_o), 32'h1);
    chk("idle_addr", imem_bus.imem_addr_o, 32'h0);
    chk("idle_valid", 32'(ifid_valid), 32'h0);
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      chk("zw_valid", 32'(ifid_valid), 32'h1);
      chk("zw_pc", ifid_pc, 32'(4 * i));
      chk("zw_pc4", ifid_pc4, 32'(4 * i + 4));
      chk("zw_instr", ifid_instr, 32'h1300_0000 | 32'(4 * i));
    end

    // reset mid-stream, then two wait cycles per access
    rst = 1'b1; lat = 2;
    step();
    rst = 1'b0;
    step();
    chk("w2_a_req", 32'(imem_bus.imem_req_o), 32'h1);
    chk("w2_a_addr", imem_bus.imem_addr_o, 32'h0);
    chk("w2_a_valid", 32'(ifid_valid), 32'h0);
    step();
    chk("w2_b_valid", 32'(ifid_valid), 32'h0);
    step();
    chk("w2_c_addr", imem_bus.imem_addr_o, 32'h0);
    step();
    chk("w2_d_valid", 32'(ifid_valid), 32'h1);
    chk("w2_d_pc", ifid_pc, 32'h0);
    chk("w2_d_addr", imem_bus.imem_addr_o, 32'h4);
    step();
    chk("w2_e_valid", 32'(ifid_valid), 32'h0);
    chk("w2_e_addr", imem_bus.imem_addr_o, 32'h4);
    step();
    chk("w2_f_valid", 32'(ifid_valid), 32'h0);
    chk("w2_f_addr", imem_bus.imem_addr_o, 32'h4);
    chk("w2_f_req", 32'(imem_bus.imem_req_o), 32'h1);
    step();
    chk("w2_g_valid", 32'(ifid_valid), 32'h1);
    chk("w2_g_pc", ifid_pc, 32'h4);
    chk("w2_g_instr", ifid_instr, 32'h1300_0004);
    chk("w2_g_addr", imem_bus.imem_addr_o, 32'h8);

    // stall for three cycles at the ack of 0x8
    lat = 0; stall = 1'b1;
    step();
    chk("st_h1_req", 32'(imem_bus.imem_req_o), 32'h0);
    chk("st_h1_valid", 32'(ifid_valid), 32'h1);
    chk("st_h1_pc", ifid_pc, 32'h4);
    chk("st_h1_pco", pc, 32'h8);
    step();
    chk("st_h2_req", 32'(imem_bus.imem_req_o), 32'h0);
    chk("st_h2_pc", ifid_pc, 32'h4);
    step();
    chk("st_h3_req", 32'(imem_bus.imem_req_o), 32'h0);
    chk("st_h3_valid", 32'(ifid_valid), 32'h1);
    chk("st_h3_pc", ifid_pc, 32'h4);
    stall = 1'b0;
    step();
    chk("st_i_valid", 32'(ifid_valid), 32'h1);
    chk("st_i_pc", ifid_pc, 32'h8);
    chk("st_i_pc4", ifid_pc4, 32'hC);
    chk("st_i_instr", ifid_instr, 32'h1300_0008);
    chk("st_i_req", 32'(imem_bus.imem_req_o), 32'h1);
    chk("st_i_addr", imem_bus.imem_addr_o, 32'hC);
    step();
    chk("st_j_pc", ifid_pc, 32'hC);
    chk("st_j_addr", imem_bus.imem_addr_o, 32'h10);

    // redirect to 0x100 while 0x10 is outstanding
    lat = 2; redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("kl_k1_addr", imem_bus.imem_addr_o, 32'h10);
    chk("kl_k1_req", 32'(imem_bus.imem_req_o), 32'h1);
    chk("kl_k1_valid", 32'(ifid_valid), 32'h0);
    chk("kl_k1_pco", pc, 32'h100);
    step();
    chk("kl_k2_addr", imem_bus.imem_addr_o, 32'h10);
    chk("kl_k2_valid", 32'(ifid_valid), 32'h0);
    step();
    chk("kl_k3_addr", imem_bus.imem_addr_o, 32'h100);
    chk("kl_k3_valid", 32'(ifid_valid), 32'h0);
    step();
    chk("kl_k4_valid", 32'(ifid_valid), 32'h0);
    step();
    chk("kl_k5_valid", 32'(ifid_valid), 32'h0);
    step();
    chk("kl_k6_valid", 32'(ifid_valid), 32'h1);
    chk("kl_k6_pc", ifid_pc, 32'h100);
    chk("kl_k6_pc4", ifid_pc4, 32'h104);
    chk("kl_k6_instr", ifid_instr, 32'h1300_0100);

    // redirect together with stall while holding 0x104; low bits of target dropped
    lat = 0; stall = 1'b1;
    step();
    chk("hr_l1_req", 32'(imem_bus.imem_req_o), 32'h0);
    chk("hr_l1_pc", ifid_pc, 32'h100);
    redirect = 1'b1; redirect_pc = 32'h203;
    step();
    chk("hr_l2_valid", 32'(ifid_valid), 32'h0);
    chk("hr_l2_req", 32'(imem_bus.imem_req_o), 32'h1);
    chk("hr_l2_addr", imem_bus.imem_addr_o, 32'h200);
    chk("hr_l2_pco", pc, 32'h200);
    stall = 1'b0; redirect = 1'b0;
    step();
    chk("hr_l3_valid", 32'(ifid_valid), 32'h1);
    chk("hr_l3_pc", ifid_pc, 32'h200);
    chk("hr_l3_instr", ifid_instr, 32'h1300_0200);
    chk("hr_l3_addr", imem_bus.imem_addr_o, 32'h204);

    // PC wrap-around at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wr_l4_valid", 32'(ifid_valid), 32'h0);
    chk("wr_l4_addr", imem_bus.imem_addr_o, 32'hFFFF_FFFC);
    chk("wr_l4_pco", pc, 32'hFFFF_FFFC);
    step();
    chk("wr_l5_pco", pc, 32'h0);
    chk("wr_l5_valid", 32'(ifid_valid), 32'h1);
    chk("wr_l5_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wr_l5_pc4", ifid_pc4, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined CPU.
- Owns the PC register and the handshake to instruction memory, and drives the IF/ID pipeline register.
- Feeds the sequential-PC adder: pc_o goes to adder input A, with B tied to 4 at the top level; the adder sum returns on seq_pc_i.
- Handles stall from hazard detection and redirect (branch/jump/flush) from later stages.

Parameters:
- WIDTH, 32, width of PC and instruction words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- stall_i  in  1  hold IF/ID register and PC; issued from hazard unit.
- redirect_i  in  1  redirect/flush request; takes priority over stall_i.
- redirect_pc_i  in  WIDTH  redirect target.
- pc_o  out  WIDTH  current PC (= pc_q); goes to sequential adder input A.
- seq_pc_i  in  WIDTH  adder sum (pc_o + 4), combinational from the same cycle.
- imem_req_o  out  1  fetch request; held high until ack.
- imem_addr_o  out  WIDTH  fetch address; stable while imem_req_o is high.
- imem_ack_i  in  1  read data valid this cycle; may arrive in the request cycle or any later cycle.
- imem_rdata_i  in  WIDTH  instruction word.
- ifid_valid_o  out  1  IF/ID register holds a live instruction.
- ifid_pc_o  out  WIDTH  PC of that instruction.
- ifid_pc4_o  out  WIDTH  its sequential PC.
- ifid_instr_o  out  WIDTH  instruction word.

Behaviour:
- Reset, synchronous, while rst=1:
  - pc_q=RESET_PC, state=IDLE.
  - imem_req_o=0; all ifid_* outputs=0; hold buffer invalid.
- Redirect target: redirect_pc_i[1:0] is ignored and forced to 00 when loaded.
- States are IDLE, REQ, KILL, HOLD.
- IDLE (one cycle after reset release):
  - req=0; goes to REQ.
  - redirect_i here loads pc_q.
- REQ: req=1, addr=pc_q; req_addr_q<=pc_q.
  - ack & redirect_i: discard the data; pc_q<=redirect target; ifid_valid<=0; stay REQ.
  - ack & !stall_i: IF/ID <= {1, pc_q, seq_pc_i, rdata}; pc_q<=seq_pc_i; stay REQ. This gives back-to-back fetch at 1/cycle with a zero-wait memory.
  - ack & stall_i: buffer <= {pc_q, seq_pc_i, rdata}; IF/ID unchanged; go HOLD.
  - no ack & redirect_i: pc_q<=redirect target; ifid_valid<=0; go KILL (outstanding request must still complete).
  - no ack & !stall_i: ifid_valid<=0 (bubble); other ifid fields unchanged.
  - no ack & stall_i: IF/ID unchanged.
- KILL: req=1, addr=req_addr_q (the old address stays stable).
  - redirect_i overwrites pc_q.
  - When !stall_i or on redirect: ifid_valid<=0.
  - ack: discard the data; go REQ next cycle with the new pc_q.
- HOLD: req=0.
  - redirect_i: drop the buffer; pc_q<=redirect target; ifid_valid<=0; go REQ.
  - !stall_i: IF/ID <= buffer with valid=1; pc_q<=buffered seq_pc; go REQ.
  - stall_i: stay.
- Combinational paths:
  - pc_o is registered, so there is no combinational loop through the adder.
  - seq_pc_i is sampled only in REQ on ack.
- Wrap-around: PC 32'hFFFF_FFFC + 4 wraps to 0. This is the adder's behaviour and is passed through without a flag.
- Reset mid-request: the outstanding request is abandoned. The memory controller is reset by the same rst.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_o[31:0] and perf_bubble_o[31:0].
  - perf_fetch_o counts cycles where IF/ID loads valid=1.
  - perf_bubble_o counts cycles where ifid_valid<=0 while !stall_i.
  - Both cleared by rst and wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared pipeline package holds:
  - the state encoding typedef (IDLE/REQ/KILL/HOLD);
  - RESET_PC default;
  - the IF/ID bundle struct {valid, pc, pc4, instr}.
- One sub-module is natural: if_hold_buf, a one-entry skid buffer (load/drop/valid) used in HOLD.

Test Plan:
- Reset then zero-wait memory (ack same cycle): ifid_pc_o steps 0,4,8,C on consecutive cycles; ifid_instr_o matches memory.
- Memory with 2 wait cycles: each instruction is valid for 1 cycle followed by 2 bubbles; addr stays 0x4 for 3 cycles while req is high.
- Stall asserted for 3 cycles at ack of PC 0x8: IF/ID holds PC 0x4; 0x8 is buffered with req low. On release, 0x8 appears, then 0xC is requested.
- Redirect to 0x100 while the request for 0x10 is pending (no ack): addr stays 0x10 until ack; that data is dropped; next addr is 0x100 and no instruction from 0x10 ever becomes valid.
- Redirect and stall in the same cycle in HOLD: buffer dropped; ifid_valid_o=0 next cycle; fetch resumes at target. redirect_pc_i=0x203 loads 0x200.
- PC at 0xFFFF_FFFC with ack: next pc_o=0x0000_0000.
